// File: rtl/fifo_unpacker.sv
// Drains DATA_WIDTH-bit words from a FIFO read port and replays each one as
// BYTE_WIDTH-bit beats on a valid/ready stream. Define FIFO_UNPACK_MSB_FIRST_EN for big-endian beat order.
module fifo_unpacker #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  output logic [BYTE_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy
);

  localparam int NUM_BEATS = DATA_WIDTH / BYTE_WIDTH;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  pop_q, pop_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] shift_adv;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  accept;

  // The outgoing beat always sits at the same end of the shift register,
  // so advancing to the next beat is a plain shift rather than a wide mux.
`ifdef FIFO_UNPACK_MSB_FIRST_EN
  assign shift_adv = shift_q << BYTE_WIDTH;
  assign m_data    = shift_q[DATA_WIDTH-1 -: BYTE_WIDTH];
`else
  assign shift_adv = shift_q >> BYTE_WIDTH;
  assign m_data    = shift_q[BYTE_WIDTH-1:0];
`endif

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign accept  = valid_q && m_ready;

  always_comb begin
    state_d = state_q;
    pop_d   = 1'b0;
    valid_d = valid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_d   = 1'b1;
          state_d = POP;
        end
      end
      POP: begin
        state_d = WAIT;
      end
      WAIT: begin
        // The FIFO updated data_out on the pop edge, so it is valid here.
        shift_d = fifo_data;
        cnt_d   = '0;
        valid_d = 1'b1;
        last_d  = (NUM_BEATS == 1);
        state_d = SEND;
      end
      SEND: begin
        if (accept) begin
          shift_d = shift_adv;
          if (cnt_q == LAST_CNT) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            cnt_d   = '0;
            if (!fifo_empty) begin
              pop_d   = 1'b1;
              state_d = POP;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d  = cnt_inc;
            last_d = (cnt_inc == LAST_CNT);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pop_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      pop_q   <= pop_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign fifo_pop = pop_q;
  assign m_valid  = valid_q;
  assign m_last   = last_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_unpacker.sv
// Directed bench for fifo_unpacker: per-cycle vector table plus hand-written
// back-to-back, empty-FIFO and mid-word-reset sequences against a queue FIFO model.
module tb_fifo_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fifo_data = '0;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] fifo_q[$];

  fifo_unpacker #(.DATA_WIDTH(32), .BYTE_WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .fifo_data(fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_pop(fifo_pop),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last(m_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (fifo_q.size() == 0);

  // FIFO model with registered read: data_out changes on the edge that samples pop.
  always @(posedge clk) begin
    if (fifo_pop === 1'b1) begin
      n_cmp++;
      if (fifo_q.size() == 0) begin
        n_mis++;
        $display("FAIL pop_safety: fifo_pop=1 while fifo_empty=1, required no pop");
      end else begin
        fifo_data <= fifo_q.pop_front();
      end
    end
  end

  localparam logic [31:0] W = 32'hA1B2C3D4;
`ifdef FIFO_UNPACK_MSB_FIRST_EN
  localparam logic [7:0] B0 = 8'hA1, B1 = 8'hB2, B2 = 8'hC3, B3 = 8'hD4;
`else
  localparam logic [7:0] B0 = 8'hD4, B1 = 8'hC3, B2 = 8'hB2, B3 = 8'hA1;
`endif

  typedef struct {
    logic        rst;
    logic        push;
    logic [31:0] word;
    logic        rdy;
    logic        pop;
    logic        vld;
    logic [7:0]  dat;
    logic        lst;
    logic        bsy;
  } vec_t;

  vec_t vt [21];

  function automatic vec_t mk(input logic rst, input logic push, input logic rdy,
                              input logic pop, input logic vld, input logic [7:0] dat,
                              input logic lst, input logic bsy);
    vec_t v;
    v.rst = rst; v.push = push; v.word = W; v.rdy = rdy;
    v.pop = pop; v.vld = vld; v.dat = dat; v.lst = lst; v.bsy = bsy;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_beat(input int k);
    int w;
    int i;
    w = k / 4;
    i = k % 4;
`ifdef FIFO_UNPACK_MSB_FIRST_EN
    return 8'(4 * w + 3 - i);
`else
    return 8'(4 * w + i);
`endif
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] bw [4];
    logic [7:0]  beats[$];
    int          pop_cyc[$];
    int          idle_visits;
    bit          done;

    reset   = 1'b1;
    m_ready = 1'b0;

    //        rst push rdy | pop vld dat    lst bsy
    vt[0]  = mk(1, 1, 0,     0, 0, 8'h00, 0, 0);
    vt[1]  = mk(1, 0, 0,     0, 0, 8'h00, 0, 0);
    vt[2]  = mk(0, 0, 1,     1, 0, 8'h00, 0, 1);
    vt[3]  = mk(0, 0, 1,     0, 0, 8'h00, 0, 1);
    vt[4]  = mk(0, 0, 1,     0, 1, B0,    0, 1);
    vt[5]  = mk(0, 0, 1,     0, 1, B1,    0, 1);
    vt[6]  = mk(0, 0, 1,     0, 1, B2,    0, 1);
    vt[7]  = mk(0, 0, 1,     0, 1, B3,    1, 1);
    vt[8]  = mk(0, 0, 1,     0, 0, 8'h00, 0, 0);
    vt[9]  = mk(0, 1, 1,     1, 0, 8'h00, 0, 1);
    vt[10] = mk(0, 0, 1,     0, 0, 8'h00, 0, 1);
    vt[11] = mk(0, 0, 1,     0, 1, B0,    0, 1);
    vt[12] = mk(0, 0, 1,     0, 1, B1,    0, 1);
    vt[13] = mk(0, 0, 0,     0, 1, B1,    0, 1);
    vt[14] = mk(0, 0, 0,     0, 1, B1,    0, 1);
    vt[15] = mk(0, 0, 0,     0, 1, B1,    0, 1);
    vt[16] = mk(0, 0, 1,     0, 1, B2,    0, 1);
    vt[17] = mk(0, 0, 1,     0, 1, B3,    1, 1);
    vt[18] = mk(0, 0, 0,     0, 1, B3,    1, 1);
    vt[19] = mk(0, 0, 1,     0, 0, 8'h00, 0, 0);
    vt[20] = mk(0, 0, 0,     0, 0, 8'h00, 0, 0);

    @(negedge clk);

    // Each row's inputs cover one rising edge; outputs are checked at the following falling edge.
    for (int i = 0; i < 21; i++) begin
      reset   = vt[i].rst;
      m_ready = vt[i].rdy;
      if (vt[i].push) fifo_q.push_back(vt[i].word);
      @(negedge clk);
      check($sformatf("vec%0d.pop", i),   32'(fifo_pop), 32'(vt[i].pop));
      check($sformatf("vec%0d.valid", i), 32'(m_valid),  32'(vt[i].vld));
      check($sformatf("vec%0d.last", i),  32'(m_last),   32'(vt[i].lst));
      check($sformatf("vec%0d.busy", i),  32'(busy),     32'(vt[i].bsy));
      if (vt[i].vld || vt[i].rst)
        check($sformatf("vec%0d.data", i), 32'(m_data), 32'(vt[i].dat));
      $display("vec%0d: rst=%0b rdy=%0b pop=%0b valid=%0b data=%02h last=%0b busy=%0b",
               i, vt[i].rst, vt[i].rdy, fifo_pop, m_valid, m_data, m_last, busy);
    end

    // Back-to-back: four queued words drain with no IDLE visit and pops 6 cycles apart.
    bw[0] = 32'h03020100; bw[1] = 32'h07060504;
    bw[2] = 32'h0B0A0908; bw[3] = 32'h0F0E0D0C;
    for (int i = 0; i < 4; i++) fifo_q.push_back(bw[i]);
    m_ready     = 1'b1;
    idle_visits = 0;
    done        = 1'b0;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      @(negedge clk);
      if (fifo_pop) pop_cyc.push_back(cyc);
      if (pop_cyc.size() > 0 && beats.size() < 16 && !busy) idle_visits++;
      if (m_valid && m_ready) begin
        beats.push_back(m_data);
        $display("b2b beat %0d: data=%02h last=%0b", beats.size() - 1, m_data, m_last);
      end
      if (beats.size() == 16 && !busy) done = 1'b1;
    end
    check("b2b.done", 32'(done), 32'd1);
    check("b2b.beat_count", 32'(beats.size()), 32'd16);
    for (int k = 0; k < 16 && k < beats.size(); k++)
      check($sformatf("b2b.beat%0d", k), 32'(beats[k]), 32'(exp_beat(k)));
    check("b2b.pop_count", 32'(pop_cyc.size()), 32'd4);
    for (int k = 1; k < pop_cyc.size(); k++)
      check($sformatf("b2b.pop_gap%0d", k), 32'(pop_cyc[k] - pop_cyc[k-1]), 32'd6);
    check("b2b.idle_visits", 32'(idle_visits), 32'd0);

    // Empty FIFO: nothing may be popped or presented regardless of m_ready.
    for (int cyc = 0; cyc < 20; cyc++) begin
      m_ready = cyc[0];
      @(negedge clk);
      check($sformatf("empty%0d.pop", cyc),   32'(fifo_pop), 32'd0);
      check($sformatf("empty%0d.valid", cyc), 32'(m_valid),  32'd0);
    end
    $display("empty: 20 cycles idle, pop=%0b valid=%0b", fifo_pop, m_valid);

    // Mid-word reset right after beat 0 is accepted.
    fifo_q.push_back(W);
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst.pre_valid", 32'(m_valid), 32'd1);
    check("midrst.pre_data",  32'(m_data),  32'(B1));
    reset   = 1'b1;
    m_ready = 1'b0;
    @(negedge clk);
    check("midrst.pop",   32'(fifo_pop), 32'd0);
    check("midrst.valid", 32'(m_valid),  32'd0);
    check("midrst.data",  32'(m_data),   32'd0);
    check("midrst.last",  32'(m_last),   32'd0);
    check("midrst.busy",  32'(busy),     32'd0);
    $display("midrst: pop=%0b valid=%0b data=%02h last=%0b busy=%0b",
             fifo_pop, m_valid, m_data, m_last, busy);
    fifo_q.delete();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("postrst.busy",  32'(busy),    32'd0);
    check("postrst.valid", 32'(m_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
